// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, price/stock check, dispense and change handshakes.
// Registered outputs, 1-cycle CHECK; dispense waits on disp_ack, change pays one unit per hop_ack.
module vend_txn_controller #(
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int PRICE_DEF  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_id,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic                restock,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  output logic                hop_req,
  input  logic                hop_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          sold_out,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_soldout,
  output logic                err_funds,
  output logic                vend_done
);

  typedef enum logic [2:0] {IDLE, CREDIT, CHECK, DISPENSE, CHANGE} state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [STOCK_W-1:0]  stock [4];
  logic [CREDIT_W-1:0] price [4];
  logic [1:0]          sel_q;
  logic [TMR_W-1:0]    tmr;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_in;
  logic [STOCK_W-1:0]  cur_stock;
  logic [CREDIT_W-1:0] cur_price;

  // Carry bit of the widened sum flags a coin that would overflow the credit register.
  assign coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value) + (CREDIT_W+1)'(1);
  assign coin_ok   = !coin_sum[CREDIT_W];
  assign credit_in = (coin_valid && coin_ok) ? coin_sum[CREDIT_W-1:0] : credit;
  assign cur_stock = stock[sel_q];
  assign cur_price = price[sel_q];
  assign busy      = (state == CHECK) || (state == DISPENSE) || (state == CHANGE);

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < 4; i++) sold_out[i] = (stock[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      sel_q       <= '0;
      tmr         <= '0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      hop_req     <= 1'b0;
      coin_reject <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
      vend_done   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stock[i] <= STOCK_W'(STOCK_INIT);
        price[i] <= CREDIT_W'(PRICE_DEF);
      end
    end else begin
      coin_reject <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
      vend_done   <= 1'b0;
      if (cfg_we) price[cfg_id] <= cfg_price;

      case (state)
        IDLE, CREDIT: begin
          if (coin_valid) begin
            if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
            else         coin_reject <= 1'b1;
          end
          if (state == IDLE && restock) begin
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT);
          end
          // Cancel outranks a simultaneous selection; only meaningful with credit held.
          if (state == CREDIT && cancel) begin
            state   <= CHANGE;
            hop_req <= 1'b1;
            tmr     <= '0;
          end else if (sel_valid) begin
            sel_q <= sel_id;
            state <= CHECK;
            tmr   <= '0;
          end else if (credit_in != '0) begin
            if (state == IDLE || coin_valid) begin
              state <= CREDIT;
              tmr   <= '0;
            end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
              state   <= CHANGE;
              hop_req <= 1'b1;
              tmr     <= '0;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
        end

        CHECK: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (cur_stock == '0) begin
            err_soldout <= 1'b1;
            state       <= (credit != '0) ? CREDIT : IDLE;
          end else if (credit < cur_price) begin
            err_funds <= 1'b1;
            state     <= (credit != '0) ? CREDIT : IDLE;
          end else begin
            credit       <= credit - cur_price;
            stock[sel_q] <= cur_stock - STOCK_W'(1);
            disp_req     <= 1'b1;
            disp_id      <= sel_q;
            state        <= DISPENSE;
          end
        end

        DISPENSE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (disp_ack) begin
            disp_req <= 1'b0;
            if (credit != '0) begin
              state   <= CHANGE;
              hop_req <= 1'b1;
            end else begin
              state     <= IDLE;
              vend_done <= 1'b1;
            end
          end
        end

        CHANGE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (hop_ack) begin
            credit <= credit - CREDIT_W'(1);
            // Last unit paid: drop the request so the hopper never sees it with zero credit.
            if (credit == CREDIT_W'(1)) begin
              hop_req   <= 1'b0;
              vend_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: one task per scenario with hand-computed expectations.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = '0;
  logic       cancel = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_id = '0;
  logic [7:0] cfg_price = '0;
  logic       restock = 1'b0;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       disp_ack = 1'b0;
  logic       hop_req;
  logic       hop_ack = 1'b0;
  logic [7:0] credit;
  logic [3:0] sold_out;
  logic       busy;
  logic       coin_reject;
  logic       err_soldout;
  logic       err_funds;
  logic       vend_done;

  int total = 0;
  int bad   = 0;

  vend_txn_controller dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_price(cfg_price),
    .restock(restock),
    .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
    .hop_req(hop_req), .hop_ack(hop_ack),
    .credit(credit), .sold_out(sold_out), .busy(busy),
    .coin_reject(coin_reject), .err_soldout(err_soldout),
    .err_funds(err_funds), .vend_done(vend_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_value = v;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id;
    step();
    sel_valid = 1'b0;
  endtask

  // Acks every hopper request until it drops; bounded so a stuck DUT still terminates.
  task automatic drain(output int n, output int vd);
    n = 0; vd = 0;
    hop_ack = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!hop_req) break;
      step();
      n++;
      vd += int'(vend_done);
    end
    hop_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (credit !== 8'd0) begin bad++; $display("FAIL reset_credit got=%0d want=0", credit); end
    total++; if ({disp_req, hop_req, busy} !== 3'b000) begin bad++; $display("FAIL reset_reqs got=%b want=000", {disp_req, hop_req, busy}); end
    total++; if (sold_out !== 4'b0000) begin bad++; $display("FAIL reset_sold_out got=%b want=0000", sold_out); end
    total++; if ({coin_reject, err_soldout, err_funds, vend_done} !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b want=0000", {coin_reject, err_soldout, err_funds, vend_done}); end
    rst = 1'b0;
    step();
    cancel = 1'b1; disp_ack = 1'b1; hop_ack = 1'b1;
    step();
    cancel = 1'b0; disp_ack = 1'b0; hop_ack = 1'b0;
    total++; if ({busy, hop_req, vend_done, credit} !== 11'd0) begin bad++; $display("FAIL idle_ignore got=%b want=0", {busy, hop_req, vend_done, credit}); end
  endtask

  task automatic test_exact_payment();
    coin(2'b01);
    total++; if (credit !== 8'd2) begin bad++; $display("FAIL exact_coin1 got=%0d want=2", credit); end
    coin(2'b00);
    total++; if (credit !== 8'd3) begin bad++; $display("FAIL exact_coin2 got=%0d want=3", credit); end
    select(2'd2);
    total++; if ({busy, disp_req} !== 2'b10) begin bad++; $display("FAIL exact_check got=%b want=10", {busy, disp_req}); end
    step();
    total++; if ({disp_req, disp_id, credit} !== {1'b1, 2'd2, 8'd0}) begin bad++; $display("FAIL exact_disp got=%b/%0d/%0d want=1/2/0", disp_req, disp_id, credit); end
    step(); step();
    total++; if ({disp_req, disp_id} !== 3'b110) begin bad++; $display("FAIL exact_hold got=%b want=110", {disp_req, disp_id}); end
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    total++; if ({disp_req, hop_req, vend_done, busy} !== 4'b0010) begin bad++; $display("FAIL exact_done got=%b want=0010", {disp_req, hop_req, vend_done, busy}); end
    step();
    total++; if (vend_done !== 1'b0) begin bad++; $display("FAIL exact_done_pulse got=%b want=0", vend_done); end
  endtask

  task automatic test_change();
    int acked = 0;
    int vd = 0;
    coin(2'b11); coin(2'b11);
    total++; if (credit !== 8'd8) begin bad++; $display("FAIL change_credit got=%0d want=8", credit); end
    select(2'd0);
    step();
    total++; if ({disp_req, disp_id, credit} !== {1'b1, 2'd0, 8'd5}) begin bad++; $display("FAIL change_disp got=%b/%0d/%0d want=1/0/5", disp_req, disp_id, credit); end
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    total++; if ({disp_req, hop_req, vend_done} !== 3'b010) begin bad++; $display("FAIL change_enter got=%b want=010", {disp_req, hop_req, vend_done}); end
    // One idle hopper cycle in the middle must not consume credit.
    for (int i = 0; i < 10; i++) begin
      if (!hop_req) break;
      hop_ack = (i != 1);
      step();
      if (i != 1) acked++;
      if (i == 1) begin
        total++; if (credit !== 8'd4) begin bad++; $display("FAIL change_gap got=%0d want=4", credit); end
      end
      vd += int'(vend_done);
    end
    hop_ack = 1'b0;
    total++; if (acked !== 5) begin bad++; $display("FAIL change_units got=%0d want=5", acked); end
    total++; if ({credit, hop_req} !== 9'd0 || vd !== 1) begin bad++; $display("FAIL change_end got=%0d/%b/%0d want=0/0/1", credit, hop_req, vd); end
  endtask

  task automatic test_soldout();
    int vends = 0;
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_price = 8'd0;
    step();
    cfg_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      select(2'd1);
      step();
      if ({disp_req, disp_id} === 3'b101) begin
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        if (vend_done === 1'b1) vends++;
      end
    end
    total++; if (vends !== 5) begin bad++; $display("FAIL soldout_vends got=%0d want=5", vends); end
    total++; if (sold_out !== 4'b0010) begin bad++; $display("FAIL soldout_flag got=%b want=0010", sold_out); end
    select(2'd1);
    step();
    total++; if ({err_soldout, err_funds, disp_req, busy} !== 4'b1000) begin bad++; $display("FAIL soldout_err got=%b want=1000", {err_soldout, err_funds, disp_req, busy}); end
    restock = 1'b1;
    step();
    restock = 1'b0;
    total++; if ({sold_out, err_soldout} !== 5'b0) begin bad++; $display("FAIL soldout_restock got=%b want=00000", {sold_out, err_soldout}); end
  endtask

  task automatic test_funds_cancel();
    coin(2'b00);
    select(2'd3);
    step();
    total++; if ({err_funds, busy, credit} !== {1'b1, 1'b0, 8'd1}) begin bad++; $display("FAIL funds_err got=%b/%b/%0d want=1/0/1", err_funds, busy, credit); end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    total++; if ({hop_req, busy} !== 2'b11) begin bad++; $display("FAIL funds_cancel got=%b want=11", {hop_req, busy}); end
    coin(2'b10);
    total++; if ({coin_reject, credit} !== {1'b1, 8'd1}) begin bad++; $display("FAIL funds_coin_reject got=%b/%0d want=1/1", coin_reject, credit); end
    hop_ack = 1'b1;
    step();
    hop_ack = 1'b0;
    total++; if ({hop_req, vend_done, coin_reject, credit} !== {3'b010, 8'd0}) begin bad++; $display("FAIL funds_refund got=%b want=010/0", {hop_req, vend_done, coin_reject, credit}); end
  endtask

  task automatic test_cancel_priority();
    int n, vd;
    coin(2'b00);
    sel_valid = 1'b1; sel_id = 2'd3; cancel = 1'b1;
    step();
    sel_valid = 1'b0; cancel = 1'b0;
    total++; if ({hop_req, disp_req, credit} !== {2'b10, 8'd1}) begin bad++; $display("FAIL cancel_prio got=%b/%0d want=10/1", {hop_req, disp_req}, credit); end
    drain(n, vd);
    total++; if (n !== 1 || vd !== 1 || err_funds !== 1'b0) begin bad++; $display("FAIL cancel_drain got=%0d/%0d want=1/1", n, vd); end
  endtask

  task automatic test_cfg_timing();
    int n, vd;
    coin(2'b11);
    select(2'd0);
    cfg_we = 1'b1; cfg_id = 2'd0; cfg_price = 8'd10;
    step();
    cfg_we = 1'b0;
    total++; if ({disp_req, credit} !== {1'b1, 8'd1}) begin bad++; $display("FAIL cfg_old_price got=%b/%0d want=1/1", disp_req, credit); end
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    drain(n, vd);
    coin(2'b11);
    select(2'd0);
    step();
    total++; if ({err_funds, credit} !== {1'b1, 8'd4}) begin bad++; $display("FAIL cfg_new_price got=%b/%0d want=1/4", err_funds, credit); end
    cfg_we = 1'b1; cfg_price = 8'd3;
    cancel = 1'b1;
    step();
    cfg_we = 1'b0; cancel = 1'b0;
    drain(n, vd);
    total++; if (n !== 4 || credit !== 8'd0) begin bad++; $display("FAIL cfg_refund got=%0d/%0d want=4/0", n, credit); end
  endtask

  task automatic test_overflow_timeout();
    int n, vd;
    coin_valid = 1'b1; coin_value = 2'b11;
    for (int i = 0; i < 63; i++) step();
    coin_value = 2'b00;
    step();
    coin_valid = 1'b0;
    total++; if (credit !== 8'd253) begin bad++; $display("FAIL ovf_fill got=%0d want=253", credit); end
    coin(2'b11);
    total++; if ({coin_reject, credit} !== {1'b1, 8'd253}) begin bad++; $display("FAIL ovf_reject got=%b/%0d want=1/253", coin_reject, credit); end
    for (int i = 0; i < 254; i++) step();
    total++; if ({hop_req, busy} !== 2'b00) begin bad++; $display("FAIL timeout_early got=%b want=00", {hop_req, busy}); end
    step();
    total++; if ({hop_req, busy} !== 2'b11) begin bad++; $display("FAIL timeout_fire got=%b want=11", {hop_req, busy}); end
    drain(n, vd);
    total++; if (n !== 253 || vd !== 1 || credit !== 8'd0 || hop_req !== 1'b0) begin bad++; $display("FAIL timeout_refund got=%0d/%0d/%0d want=253/1/0", n, vd, credit); end
  endtask

  task automatic test_reset_mid();
    int n, vd;
    cfg_we = 1'b1; cfg_id = 2'd3; cfg_price = 8'd1;
    step();
    cfg_we = 1'b0;
    coin(2'b11);
    select(2'd0);
    step();
    total++; if ({disp_req, credit} !== {1'b1, 8'd1}) begin bad++; $display("FAIL mid_disp got=%b/%0d want=1/1", disp_req, credit); end
    #2 rst = 1'b1;
    #1;
    total++; if ({disp_req, hop_req, busy, credit} !== 11'd0) begin bad++; $display("FAIL mid_async got=%b want=0", {disp_req, hop_req, busy, credit}); end
    step();
    rst = 1'b0;
    coin(2'b00);
    select(2'd3);
    step();
    total++; if ({err_funds, disp_req, credit} !== {2'b10, 8'd1}) begin bad++; $display("FAIL mid_price_default got=%b/%0d want=10/1", {err_funds, disp_req}, credit); end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    drain(n, vd);
    total++; if (n !== 1 || vd !== 1) begin bad++; $display("FAIL mid_refund got=%0d/%0d want=1/1", n, vd); end
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_change();
    test_soldout();
    test_funds_cancel();
    test_cancel_priority();
    test_cfg_timing();
    test_overflow_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
